bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter, successor to the single-digit mod-10 counter. Counts 0 to 10^DIGITS−1 in packed BCD, with count enable, direction control, synchronous parallel load with digit validation, and a terminal-count output for cascading instances. Used wherever the design needs decimal event counts, timers or display-ready values.

## Interface
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  4*DIGITS  packed BCD value to load; digit i at [4i+3:4i]
- q  output  4*DIGITS  registered packed BCD count; digit 0 least significant
- tc  output  1  terminal count, combinational: en & (up ? q == all 9s : q == all 0s)
- err  output  1  registered sticky flag: last load contained a digit > 9

## Operation
- Priority per clock edge: reset > load > en > hold.
- reset: q = 0, err = 0.
- load: each digit of load_val ≤ 9 is loaded unchanged; any digit > 9 is loaded as 0. err = 1 if any digit > 9, else err = 0. en is ignored in a load cycle.
- en & up: decimal increment with ripple carry; digit 9 → 0 and carries into the next digit. All 9s wraps to all 0s.
- en & ~up: decimal decrement with ripple borrow; digit 0 → 9 and borrows. All 0s wraps to all 9s.
- ~en & ~load: q and err hold.
- err changes only on reset or load. It is never set or cleared by counting.
- q never holds a nibble > 9 in any reachable state.
- tc feeds the en of a higher-order instance. Cascaded chains count as one wider counter, with the same up applied to all instances.
- Direction may change on any cycle. It takes effect on the step made at that edge.

## Timing
- Latency: a load or count step sampled at edge k is visible on q after edge k. One cycle.
- tc is combinational from the en, up and q values of the current cycle. There is no registered delay, so cascades step in the same edge.
- tc is high during the cycle in which the wrap occurs at the next edge, not after it.
- After reset deassertion, the first count step happens at the first edge with en = 1.
- If reset is asserted mid-count, q = 0 at the next edge regardless of load or en.
- load and en both high: the load wins. tc still reflects the pre-load q and en in that cycle.
- Carry and borrow chains are purely combinational across DIGITS. At DIGITS = 8 they are the critical path, which is acceptable at the target clock.

## Structure
- Package bcd_counter_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - function bcd_valid(nibble)
- Sub-module bcd_digit implements one digit and is instantiated DIGITS times via generate.
  - Inputs: clk, reset, load, ld_digit (already sanitised), step, up.
  - Outputs: digit, carry_out (digit == 9 & up), borrow_out (digit == 0 & ~up).
  - step for digit i = en & ~load & AND of carry/borrow terms of digits 0..i−1.
- The top level does the load sanitising, err generation and tc.

## Test plan
- Reset and up-count, DIGITS = 2: reset, then en = 1, up = 1 for 100 cycles. q steps 00, 01 … 99, 00. tc is high only in the cycle where q = 8'h99.
- Down-count wrap: load 8'h01, then en = 1, up = 0. q goes 01 → 00 → 99 → 98. tc is high only while q = 00.
- Invalid load: load_val = 8'h5C gives q = 8'h50 and err = 1. A later load of 8'h37 gives q = 8'h37 and err = 0. Counting in between leaves err unchanged.
- Priority: with load = 1, en = 1 and reset = 1 together, q = 0 next cycle. With load = 1 and en = 1, q = load_val with no step. With en = 0, q holds for 10 cycles.
- Direction change: from q = 8'h10, up = 1 for 3 steps, then up = 0 for 5 steps. q goes 10, 11, 12, 13, 12, 11, 10, 09, 08.
- Cascade: two DIGITS = 1 instances with instance 0's tc driving instance 1's en. Their output matches a single DIGITS = 2 instance cycle-for-cycle over 250 random en/up/load cycles.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// ----------------------------------------------------------------------------
// bcd_counter_pkg
// Shared constants and helpers for the packed-BCD up/down counter.
//   BCD_W      : width of one BCD digit
//   BCD_MAX    : largest legal digit value (9)
//   BCD_MIN    : smallest legal digit value (0)
//   bcd_valid  : returns 1 when a nibble holds a legal BCD digit
// ----------------------------------------------------------------------------
package bcd_counter_pkg;

   localparam int             BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

   function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage : bcd_counter_pkg

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
// One decimal digit of the counter. Loads, increments or decrements by one
// with wrap (9->0 up, 0->9 down) and reports whether it will pass a carry or
// borrow to the next digit.
// Ports:
//   clk        in  rising-edge clock
//   reset      in  synchronous active-high clear
//   load       in  parallel load strobe (wins over step)
//   ld_digit   in  value to load, already guaranteed to be 0..9
//   step       in  advance this digit by one in direction 'up'
//   up         in  1 = increment, 0 = decrement
//   digit      out registered digit value
//   carry_out  out digit == 9 while counting up
//   borrow_out out digit == 0 while counting down
// ----------------------------------------------------------------------------
module bcd_digit
   import bcd_counter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_digit,
   input  logic             step,
   input  logic             up,
   output logic [BCD_W-1:0] digit,
   output logic             carry_out,
   output logic             borrow_out
);

   logic [BCD_W-1:0] r_digit;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of its sources, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_digit <= BCD_MIN;
      end else if (load) begin
         r_digit <= ld_digit;
      end else if (step) begin
         if (up) begin
            r_digit <= (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
         end else begin
            r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
         end
      end
   end

   assign digit      = r_digit;
   assign carry_out  = (r_digit == BCD_MAX) &  up;
   assign borrow_out = (r_digit == BCD_MIN) & ~up;

endmodule : bcd_digit

// File: rtl/bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// bcd_updown_counter
// Parametrised multi-digit packed-BCD up/down counter with enable, parallel
// load (illegal digits replaced by 0 and flagged), and a combinational
// terminal count for cascading.
// Parameters:
//   DIGITS   number of BCD digits (1..8)
// Ports:
//   clk       in  rising-edge clock
//   reset     in  synchronous active-high clear of q and err
//   en        in  count enable, one step per cycle
//   up        in  1 = increment, 0 = decrement
//   load      in  parallel load strobe (priority over en)
//   load_val  in  packed BCD value to load, digit i at [4i+3:4i]
//   q         out registered packed BCD count
//   tc        out en & (q is all 9s counting up / all 0s counting down)
//   err       out sticky flag: last load held a digit > 9
// ----------------------------------------------------------------------------
module bcd_updown_counter
   import bcd_counter_pkg::*;
#(
   parameter int DIGITS = 2
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    up,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] load_val,
   output logic [BCD_W*DIGITS-1:0] q,
   output logic                    tc,
   output logic                    err
);

   logic [BCD_W*DIGITS-1:0] w_ld_clean;
   logic [DIGITS-1:0]       w_nib_bad;
   logic [DIGITS-1:0]       w_carry;
   logic [DIGITS-1:0]       w_borrow;
   logic [DIGITS-1:0]       w_term;
   logic [DIGITS-1:0]       w_step;
   logic                    r_err;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign w_nib_bad[g] = !bcd_valid(load_val[g*BCD_W +: BCD_W]);
      assign w_ld_clean[g*BCD_W +: BCD_W] =
         w_nib_bad[g] ? BCD_MIN : load_val[g*BCD_W +: BCD_W];

      // A digit passes the step on only when it is about to wrap in the
      // current direction; carry and borrow are mutually exclusive via 'up'.
      assign w_term[g] = w_carry[g] | w_borrow[g];

      if (g == 0) begin : g_lsd
         assign w_step[g] = en & ~load;
      end else begin : g_upper
         assign w_step[g] = w_step[g-1] & w_term[g-1];
      end

      bcd_digit u_digit (
         .clk        (clk),
         .reset      (reset),
         .load       (load),
         .ld_digit   (w_ld_clean[g*BCD_W +: BCD_W]),
         .step       (w_step[g]),
         .up         (up),
         .digit      (q[g*BCD_W +: BCD_W]),
         .carry_out  (w_carry[g]),
         .borrow_out (w_borrow[g])
      );
   end

   // err only moves on reset or load; counting never touches it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (load) begin
         r_err <= |w_nib_bad;
      end
   end

   assign err = r_err;

   // tc deliberately ignores load so it reflects the pre-load count.
   assign tc = en & (&w_term);

endmodule : bcd_updown_counter

// File: tb/tb_bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_updown_counter
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences, and a randomised run against an integer reference model, with a
// two-instance single-digit cascade compared against the two-digit counter.
// ----------------------------------------------------------------------------
module tb_bcd_updown_counter;

   logic       clk = 1'b0;
   logic       reset, en, up, load;
   logic [7:0] load_val;

   logic [7:0] q;
   logic       tc, err;

   logic [3:0] c0_q, c1_q;
   logic       c0_tc, c1_tc, c0_err, c1_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(2)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .err(err)
   );

   bcd_updown_counter #(.DIGITS(1)) u_c0 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val[3:0]), .q(c0_q), .tc(c0_tc), .err(c0_err)
   );

   bcd_updown_counter #(.DIGITS(1)) u_c1 (
      .clk(clk), .reset(reset), .en(c0_tc), .up(up), .load(load),
      .load_val(load_val[7:4]), .q(c1_q), .tc(c1_tc), .err(c1_err)
   );

   typedef struct {
      logic       reset;
      logic       load;
      logic       en;
      logic       up;
      logic [7:0] load_val;
      logic       exp_tc;   // before the edge
      logic [7:0] exp_q;    // after the edge
      logic       exp_err;  // after the edge
   } vec_t;

   vec_t vecs[17];

   // Reference model state: plain integer count 0..99 and sticky error bit.
   int m_val;
   bit m_err;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   task automatic drive(input logic r, input logic l, input logic e,
                        input logic u, input logic [7:0] lv);
      @(negedge clk);
      reset = r; load = l; en = e; up = u; load_val = lv;
      #1;
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   // Model step from the specification's rules, in decimal arithmetic.
   task automatic model_step(input logic r, input logic l, input logic e,
                             input logic u, input logic [7:0] lv);
      int hi, lo;
      if (r) begin
         m_val = 0;
         m_err = 0;
      end else if (l) begin
         hi = int'(lv[7:4]);
         lo = int'(lv[3:0]);
         m_err = (hi > 9) || (lo > 9);
         if (hi > 9) hi = 0;
         if (lo > 9) lo = 0;
         m_val = hi * 10 + lo;
      end else if (e) begin
         m_val = u ? (m_val + 1) % 100 : (m_val + 99) % 100;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic r, l, e, u, exp_tc;
      logic [7:0] lv;
      logic [7:0] dir_exp [8];
      logic       dir_up  [8];

      reset = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_val = 8'h00;

      //               rst  ld   en   up   lval   tc   q      err
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0}; // reset
      vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h01,1'b0,8'h01,1'b0}; // load 01
      vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,1'b0}; // 01->00
      vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,8'h99,1'b0}; // 00->99, tc
      vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h98,1'b0}; // 99->98
      vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,8'h5C,1'b0,8'h50,1'b1}; // invalid load
      vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b0,8'h51,1'b1}; // err sticks
      vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h50,1'b1};
      vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,8'h37,1'b0,8'h37,1'b0}; // valid load clears
      vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,8'h45,1'b0,8'h00,1'b0}; // reset wins
      vecs[10] = '{1'b0,1'b1,1'b0,1'b0,8'h99,1'b0,8'h99,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b1,8'h00,1'b0}; // 99->00, tc
      vecs[12] = '{1'b0,1'b1,1'b1,1'b1,8'h42,1'b0,8'h42,1'b0}; // load beats en
      vecs[13] = '{1'b0,1'b1,1'b1,1'b0,8'h7A,1'b0,8'h70,1'b1}; // low nibble bad
      vecs[14] = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0};
      vecs[15] = '{1'b0,1'b1,1'b1,1'b0,8'hA3,1'b1,8'h03,1'b1}; // tc uses pre-load q
      vecs[16] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0};

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].reset, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_val);
         check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
         edge_settle();
         check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      end

      // Full up-count from 00 through 99 and back to 00.
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
         check($sformatf("upcnt%0d_q", i), 32'(q), 32'(to_bcd(i)));
         check($sformatf("upcnt%0d_tc", i), 32'(tc), 32'(i == 99));
         edge_settle();
      end
      check("upcnt_wrap_q", 32'(q), 32'h00);

      // Direction change from 10.
      dir_up  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      dir_exp = '{8'h11, 8'h12, 8'h13, 8'h12, 8'h11, 8'h10, 8'h09, 8'h08};
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
      edge_settle();
      check("dir_load_q", 32'(q), 32'h10);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'b1, dir_up[i], 8'h00);
         edge_settle();
         check($sformatf("dir%0d_q", i), 32'(q), 32'(dir_exp[i]));
      end

      // Hold with en low for 10 cycles, direction toggling.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'(i), 8'h00);
         check($sformatf("hold%0d_tc", i), 32'(tc), 32'h0);
         edge_settle();
         check($sformatf("hold%0d_q", i), 32'(q), 32'h08);
         check($sformatf("hold%0d_err", i), 32'(err), 32'h0);
      end

      // Randomised run: model vs two-digit DUT vs single-digit cascade.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      edge_settle();
      m_val = 0;
      m_err = 0;
      for (int i = 0; i < 250; i++) begin
         r  = ($urandom_range(0, 99) < 3);
         l  = ($urandom_range(0, 99) < 10);
         e  = ($urandom_range(0, 99) < 80);
         u  = ($urandom_range(0, 99) < 60);
         lv = 8'($urandom);
         // Bias toward the wrap points so tc fires often.
         if (l && $urandom_range(0, 3) == 0) lv = $urandom_range(0, 1) ? 8'h99 : 8'h00;
         drive(r, l, e, u, lv);
         exp_tc = e & (u ? (m_val == 99) : (m_val == 0));
         check($sformatf("rnd%0d_tc", i), 32'(tc), 32'(exp_tc));
         check($sformatf("rnd%0d_cas_tc", i), 32'(c1_tc), 32'(exp_tc));
         edge_settle();
         model_step(r, l, e, u, lv);
         check($sformatf("rnd%0d_q", i), 32'(q), 32'(to_bcd(m_val)));
         check($sformatf("rnd%0d_err", i), 32'(err), 32'(m_err));
         check($sformatf("rnd%0d_cas_q", i), 32'({c1_q, c0_q}), 32'(to_bcd(m_val)));
         check($sformatf("rnd%0d_cas_err", i), 32'(c1_err | c0_err), 32'(m_err));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bcd_updown_counter
